// File: rtl/enc16_4_seq.sv
// Sequential 16-to-4 priority encoder: latches a multi-hot request vector and
// presents one set-bit index per ready handshake, highest index first.
module enc16_4_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] req,
    input  logic        ready,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        valid,
    output logic        busy,
    output logic [4:0]  remaining,
    output logic        done,
    output logic        none
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pending, pending_nxt, pending_clr;
    logic [3:0]  idx, idx_nxt;
    logic [4:0]  remaining_nxt;
    logic        valid_nxt, done_nxt, none_nxt;

    function automatic logic [3:0] msb_index(input logic [15:0] v);
        msb_index = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i]) msb_index = i[3:0];
        end
    endfunction

    function automatic logic [4:0] pop_count(input logic [15:0] v);
        pop_count = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            pop_count = pop_count + {4'b0000, v[i]};
        end
    endfunction

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        idx_nxt       = idx;
        remaining_nxt = remaining;
        valid_nxt     = valid;
        done_nxt      = 1'b0;
        none_nxt      = 1'b0;
        pending_clr   = pending & ~(16'h0001 << idx);

        case (state)
            IDLE: begin
                if (load) begin
                    if (|req) begin
                        pending_nxt   = req;
                        idx_nxt       = msb_index(req);
                        remaining_nxt = pop_count(req);
                        valid_nxt     = 1'b1;
                        state_nxt     = EMIT;
                    end else begin
                        none_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (ready) begin
                    pending_nxt   = pending_clr;
                    remaining_nxt = remaining - 5'd1;
                    // last index keeps its value on a,b,c,d after the final handshake
                    if (pending_clr == '0) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = msb_index(pending_clr);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            idx       <= '0;
            remaining <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
            none      <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            idx       <= idx_nxt;
            remaining <= remaining_nxt;
            valid     <= valid_nxt;
            done      <= done_nxt;
            none      <= none_nxt;
        end
    end

    assign {a, b, c, d} = idx;
    assign busy         = (state == EMIT);

endmodule

// File: tb/tb_enc16_4_seq.sv
// Self-checking bench for enc16_4_seq: directed scenarios plus a randomized run
// against a queue-based reference model and a decoded one-hot scoreboard.
module tb_enc16_4_seq;

    logic        clk = 1'b0;
    logic        rst, load, ready;
    logic [15:0] req;
    logic        a, b, c, d, valid, busy, done, none;
    logic [4:0]  remaining;

    int checks = 0;
    int errors = 0;

    enc16_4_seq dut (
        .clk(clk), .rst(rst), .load(load), .req(req), .ready(ready),
        .a(a), .b(b), .c(c), .d(d), .valid(valid), .busy(busy),
        .remaining(remaining), .done(done), .none(none)
    );

    always #5 clk = ~clk;

    // {valid,busy,done,none,remaining[4:0],index[3:0]}
    function automatic logic [12:0] outs();
        return {valid, busy, done, none, remaining, a, b, c, d};
    endfunction

    function automatic logic [12:0] expv(input bit v, input bit bz, input bit dn,
                                         input bit nn, input int rem, input int ix);
        logic [4:0] r5;
        logic [3:0] i4;
        r5 = rem[4:0];
        i4 = ix[3:0];
        return {v, bz, dn, nn, r5, i4};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; req = 16'hFFFF; ready = 1'b1;
        tick(); tick();
        checks++;
        if (outs() !== expv(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", outs(), expv(0, 0, 0, 0, 0, 0));
        end
        rst = 1'b0; load = 1'b0; ready = 1'b0;
        tick();
        checks++;
        if (outs() !== expv(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", outs(), expv(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_two_bits();
        load = 1'b1; req = 16'h8001; ready = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (outs() !== expv(1, 1, 0, 0, 2, 15)) begin
            errors++;
            $display("FAIL two_bits_c1 got=%h want=%h", outs(), expv(1, 1, 0, 0, 2, 15));
        end
        tick();
        checks++;
        if (outs() !== expv(1, 1, 0, 0, 1, 0)) begin
            errors++;
            $display("FAIL two_bits_c2 got=%h want=%h", outs(), expv(1, 1, 0, 0, 1, 0));
        end
        tick();
        checks++;
        if (outs() !== expv(0, 0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL two_bits_done got=%h want=%h", outs(), expv(0, 0, 1, 0, 0, 0));
        end
        ready = 1'b0;
        tick();
        checks++;
        if (outs() !== expv(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL two_bits_done_pulse got=%h want=%h", outs(), expv(0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_zero_load();
        load = 1'b1; req = 16'h0000; ready = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (outs() !== expv(0, 0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL zero_none got=%h want=%h", outs(), expv(0, 0, 0, 1, 0, 0));
        end
        tick();
        checks++;
        if (outs() !== expv(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL zero_after got=%h want=%h", outs(), expv(0, 0, 0, 0, 0, 0));
        end
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        load = 1'b1; req = 16'hFFFF; ready = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (outs() !== expv(1, 1, 0, 0, 16 - i, 15 - i)) begin
                errors++;
                $display("FAIL full_step%0d got=%h want=%h", i, outs(), expv(1, 1, 0, 0, 16 - i, 15 - i));
            end
            tick();
        end
        checks++;
        if (outs() !== expv(0, 0, 1, 0, 0, 0)) begin
            errors++;
            $display("FAIL full_done got=%h want=%h", outs(), expv(0, 0, 1, 0, 0, 0));
        end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        load = 1'b1; req = 16'h0420; ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (outs() !== expv(1, 1, 0, 0, 2, 10)) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h want=%h", k, outs(), expv(1, 1, 0, 0, 2, 10));
            end
            load  = (k == 1);
            req   = (k == 1) ? 16'hFFFF : 16'h1234;
            ready = (k == 2);
            tick();
        end
        checks++;
        if (outs() !== expv(1, 1, 0, 0, 1, 5)) begin
            errors++;
            $display("FAIL stall_next got=%h want=%h", outs(), expv(1, 1, 0, 0, 1, 5));
        end
        load = 1'b1; req = 16'hFFFF; ready = 1'b1;
        tick();
        checks++;
        if (outs() !== expv(0, 0, 1, 0, 0, 5)) begin
            errors++;
            $display("FAIL stall_final_load_ignored got=%h want=%h", outs(), expv(0, 0, 1, 0, 0, 5));
        end
        load = 1'b0; ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        load = 1'b1; req = 16'h00F0; ready = 1'b1;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (outs() !== expv(1, 1, 0, 0, 3, 6)) begin
            errors++;
            $display("FAIL rstmid_pre got=%h want=%h", outs(), expv(1, 1, 0, 0, 3, 6));
        end
        rst = 1'b1;
        tick();
        checks++;
        if (outs() !== expv(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rstmid_clear got=%h want=%h", outs(), expv(0, 0, 0, 0, 0, 0));
        end
        rst = 1'b0; load = 1'b1; req = 16'h0008; ready = 1'b0;
        tick();
        checks++;
        if (outs() !== expv(1, 1, 0, 0, 1, 3)) begin
            errors++;
            $display("FAIL rstmid_reload got=%h want=%h", outs(), expv(1, 1, 0, 0, 1, 3));
        end
        load = 1'b0; ready = 1'b1;
        tick();
        checks++;
        if (outs() !== expv(0, 0, 1, 0, 0, 3)) begin
            errors++;
            $display("FAIL rstmid_done got=%h want=%h", outs(), expv(0, 0, 1, 0, 0, 3));
        end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int          q[$];
        bit          m_busy, m_done, m_none;
        int          m_idx;
        logic [15:0] loaded, acc, onehot;
        int          sel;

        rst = 1'b1; load = 1'b0; ready = 1'b0;
        tick();
        rst = 1'b0;
        m_busy = 0; m_done = 0; m_none = 0; m_idx = 0;
        loaded = '0; acc = '0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            load  = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 2) != 0);
            sel   = $urandom_range(0, 9);
            if (sel == 0)      req = 16'h0000;
            else if (sel < 4)  req = 16'h0001 << $urandom_range(0, 15);
            else if (sel < 6)  req = $urandom & $urandom;
            else               req = $urandom;

            if (valid && ready) begin
                onehot = 16'h0001 << {a, b, c, d};
                checks++;
                if ((acc & onehot) != 0 || (loaded & onehot) == 0) begin
                    errors++;
                    $display("FAIL sb_bit cyc=%0d got=%h loaded=%h seen=%h", cyc, onehot, loaded, acc);
                end
                acc = acc | onehot;
            end

            m_done = 0;
            m_none = 0;
            if (!m_busy) begin
                if (load) begin
                    if (req == 0) begin
                        m_none = 1;
                    end else begin
                        q.delete();
                        for (int k = 15; k >= 0; k--) if (req[k]) q.push_back(k);
                        loaded = req;
                        acc    = '0;
                        m_busy = 1;
                        m_idx  = q[0];
                    end
                end
            end else if (ready) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_idx = q[0];
                end
            end

            tick();
            checks++;
            if (outs() !== expv(m_busy, m_busy, m_done, m_none, q.size(), m_idx)) begin
                errors++;
                $display("FAIL rand cyc=%0d got=%h want=%h", cyc, outs(),
                         expv(m_busy, m_busy, m_done, m_none, q.size(), m_idx));
            end
            if (m_done) begin
                checks++;
                if (acc !== loaded) begin
                    errors++;
                    $display("FAIL sb_vector cyc=%0d got=%h want=%h", cyc, acc, loaded);
                end
            end
        end
        load = 1'b0; ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; ready = 1'b0; req = '0;
        test_reset();
        test_two_bits();
        test_zero_load();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
